// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a 16:1 mux through all channels, samples each after SETTLE
// cycles and hands the assembled word downstream over valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  output logic [3:0]  mux_sel,
  output logic        mux_u,
  input  logic        mux_v,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);
  state_t      state_q;
  logic [3:0]  sel_q;
  logic [7:0]  cnt_q;
  logic [15:0] data_q;
  logic        mux_u_q;
  logic        valid_q;
  logic        busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mux_u_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mux_u_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SCAN;
          sel_q   <= '0;
          cnt_q   <= RELOAD;
          data_q  <= '0;
          mux_u_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        SCAN: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          // mux output is inverted while enabled, so store the complement
          data_q[sel_q] <= ~mux_v;
          if (sel_q == 4'd15) begin
            state_q <= HOLD;
            sel_q   <= '0;
            mux_u_q <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            sel_q <= sel_q + 4'd1;
            cnt_q <= RELOAD;
          end
        end
        HOLD: if (out_ready) begin
          valid_q <= 1'b0;
          if (cont) begin
            state_q <= SCAN;
            sel_q   <= '0;
            cnt_q   <= RELOAD;
            data_q  <= '0;
            mux_u_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mux_sel   = sel_q;
  assign mux_u     = mux_u_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed checks of three sequencers (SETTLE 4, 1, 255), each
// driving its own behavioural mux that outputs inverted channel data while enabled.
module tb_mux_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st [3];
  logic        co [3];
  logic        ab [3];
  logic        rd [3];
  logic [3:0]  sel [3];
  logic        mu [3];
  logic        mv [3];
  logic [15:0] dat [3];
  logic        vld [3];
  logic        bsy [3];
  logic [15:0] chan [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_mux
    assign mv[g] = mu[g] ? 1'b1 : ~chan[g][sel[g]];
  end

  mux_scan_sequencer #(.SETTLE(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .cont(co[0]), .abort(ab[0]),
    .mux_sel(sel[0]), .mux_u(mu[0]), .mux_v(mv[0]), .out_data(dat[0]),
    .out_valid(vld[0]), .out_ready(rd[0]), .busy(bsy[0]));
  mux_scan_sequencer #(.SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .cont(co[1]), .abort(ab[1]),
    .mux_sel(sel[1]), .mux_u(mu[1]), .mux_v(mv[1]), .out_data(dat[1]),
    .out_valid(vld[1]), .out_ready(rd[1]), .busy(bsy[1]));
  mux_scan_sequencer #(.SETTLE(255)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .cont(co[2]), .abort(ab[2]),
    .mux_sel(sel[2]), .mux_u(mu[2]), .mux_v(mv[2]), .out_data(dat[2]),
    .out_valid(vld[2]), .out_ready(rd[2]), .busy(bsy[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {mux_u, out_valid, busy, mux_sel}
  function automatic logic [6:0] stat(input int i);
    return {mu[i], vld[i], bsy[i], sel[i]};
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; co[i] = 0; ab[i] = 0; rd[i] = 0; chan[i] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("reset_stat", 32'(stat(0)), 32'b1_0_0_0000);
    chk("reset_data", 32'(dat[0]), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_stat", 32'(stat(0)), 32'b1_0_0_0000);

    // single scan, start held high throughout SCAN, downstream not ready
    chan[0] = 16'hA5C3;
    st[0] = 1;
    tick();
    chk("scan_e0", 32'(stat(0)), 32'b0_0_1_0000);
    for (int e = 1; e < 64; e++) begin
      tick();
      chk($sformatf("scan_e%0d", e), 32'(stat(0)), 32'({3'b001, 4'(e / 4)}));
    end
    tick();
    st[0] = 0;
    chk("scan_e64_stat", 32'(stat(0)), 32'b1_1_1_0000);
    chk("scan_e64_data", 32'(dat[0]), 32'hA5C3);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_stat", 32'(stat(0)), 32'b1_1_1_0000);
      chk("bp_data", 32'(dat[0]), 32'hA5C3);
    end
    rd[0] = 1;
    tick();
    rd[0] = 0;
    chk("accept_stat", 32'(stat(0)), 32'b1_0_0_0000);
    tick();
    chk("stay_idle", 32'(stat(0)), 32'b1_0_0_0000);

    // abort at channel 9, with abort winning over a simultaneous start
    chan[0] = 16'h1234;
    st[0] = 1;
    tick();
    st[0] = 0;
    repeat (36) tick();
    chk("pre_abort_sel", 32'(sel[0]), 32'd9);
    ab[0] = 1;
    st[0] = 1;
    tick();
    chk("abort_stat", 32'(stat(0)), 32'b1_0_0_0000);
    chk("abort_data", 32'(dat[0]), 32'h0);
    tick();
    chk("abort_vs_start", 32'(stat(0)), 32'b1_0_0_0000);
    ab[0] = 0;
    chan[0] = 16'h5A0F;
    tick();
    st[0] = 0;
    repeat (63) tick();
    chk("fresh_e63_valid", 32'(vld[0]), 32'd0);
    tick();
    chk("fresh_e64_valid", 32'(vld[0]), 32'd1);
    chk("fresh_e64_data", 32'(dat[0]), 32'h5A0F);
    rd[0] = 1;
    tick();
    rd[0] = 0;
    chk("fresh_accept", 32'(stat(0)), 32'b1_0_0_0000);

    // continuous mode with SETTLE = 1
    chan[1] = 16'hFFFF;
    co[1] = 1;
    rd[1] = 1;
    st[1] = 1;
    tick();
    st[1] = 0;
    for (int e = 1; e < 16; e++) begin
      tick();
      chk($sformatf("s1_e%0d_sel", e), 32'(sel[1]), 32'(e));
    end
    chk("s1_e15_valid", 32'(vld[1]), 32'd0);
    tick();
    chan[1] = 16'h0001;
    chk("s1_e16_valid", 32'(vld[1]), 32'd1);
    chk("s1_e16_data", 32'(dat[1]), 32'hFFFF);
    tick();
    chk("s1_e17_stat", 32'(stat(1)), 32'b0_0_1_0000);
    chk("s1_e17_data", 32'(dat[1]), 32'h0);
    repeat (15) tick();
    chk("s1_e32_valid", 32'(vld[1]), 32'd0);
    co[1] = 0;
    tick();
    chk("s1_e33_valid", 32'(vld[1]), 32'd1);
    chk("s1_e33_data", 32'(dat[1]), 32'h0001);
    tick();
    rd[1] = 0;
    chk("s1_e34_stat", 32'(stat(1)), 32'b1_0_0_0000);

    // SETTLE = 255
    chan[2] = 16'hC001;
    st[2] = 1;
    tick();
    st[2] = 0;
    repeat (4079) tick();
    chk("s255_e4079_valid", 32'(vld[2]), 32'd0);
    chk("s255_e4079_sel", 32'(sel[2]), 32'd15);
    tick();
    chk("s255_e4080_valid", 32'(vld[2]), 32'd1);
    chk("s255_e4080_data", 32'(dat[2]), 32'hC001);

    // asynchronous reset mid-scan at channel 7
    chan[0] = 16'hFFFF;
    st[0] = 1;
    tick();
    st[0] = 0;
    repeat (30) tick();
    chk("pre_rst_sel", 32'(sel[0]), 32'd7);
    chk("pre_rst_data", 32'(dat[0]), 32'h007F);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_stat", 32'(stat(0)), 32'b1_0_0_0000);
    chk("rst_mid_data", 32'(dat[0]), 32'h0);
    chk("rst_hold_c", 32'(stat(2)), 32'b1_0_0_0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
